// File: rtl/modexp_pkg.sv
// Shared definitions for the modular-exponentiation controller:
// FSM state encoding and default operand/exponent widths.
package modexp_pkg;

  localparam int DEFAULT_N   = 1024;
  localparam int DEFAULT_E_W = 1024;

  typedef enum logic [3:0] {
    IDLE,
    PRE,
    PRE_WAIT,
    SQ,
    SQ_WAIT,
    MUL,
    MUL_WAIT,
    POST,
    POST_WAIT,
    FIN
  } state_t;

endpackage

// File: rtl/exp_bit_scanner.sv
// Exponent shift register and bit counter, MSB first. With MODEXP_SKIP_LZ_EN
// defined, the scan starts at the most-significant set bit of the exponent.
module exp_bit_scanner
  import modexp_pkg::*;
#(
  parameter int E_W = DEFAULT_E_W
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           load,
  input  logic           advance,
  input  logic [E_W-1:0] e_in,
  output logic           cur_bit,
  output logic           last_bit,
  output logic           exp_zero
);

  localparam int CW = (E_W > 1) ? $clog2(E_W) : 1;

  logic [E_W-1:0] e_sh;
  logic [CW-1:0]  bit_cnt;

`ifdef MODEXP_SKIP_LZ_EN
  logic [CW-1:0] lz_msb;
  logic          zero_q;

  // Highest set bit index; zero for e=0, which is then flagged separately.
  always_comb begin
    lz_msb = '0;
    for (int i = 0; i < E_W; i++) begin
      if (e_in[i]) lz_msb = CW'(i);
    end
  end

  assign exp_zero = zero_q;
`else
  assign exp_zero = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      e_sh    <= '0;
      bit_cnt <= '0;
`ifdef MODEXP_SKIP_LZ_EN
      zero_q  <= 1'b0;
`endif
    end else if (load) begin
`ifdef MODEXP_SKIP_LZ_EN
      e_sh    <= e_in << (CW'(E_W - 1) - lz_msb);
      bit_cnt <= lz_msb;
      zero_q  <= (e_in == '0);
`else
      e_sh    <= e_in;
      bit_cnt <= CW'(E_W - 1);
`endif
    end else if (advance) begin
      e_sh    <= e_sh << 1;
      bit_cnt <= bit_cnt - 1'b1;
    end
  end

  assign cur_bit  = e_sh[E_W-1];
  assign last_bit = (bit_cnt == '0);

endmodule

// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply controller driving an external Montgomery
// multiplier. Optional leading-zero skip via MODEXP_SKIP_LZ_EN (see exp_bit_scanner).
module modexp_ctrl
  import modexp_pkg::*;
#(
  parameter int N   = DEFAULT_N,
  parameter int E_W = DEFAULT_E_W
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           start,
  input  logic [N-1:0]   in_x,
  input  logic [N-1:0]   in_m,
  input  logic [N-1:0]   in_r,
  input  logic [N-1:0]   in_r2,
  input  logic [E_W-1:0] in_e,
  output logic [N-1:0]   result,
  output logic           done,
  output logic           busy,
  output logic           mont_start,
  output logic [N-1:0]   mont_a,
  output logic [N-1:0]   mont_b,
  output logic [N-1:0]   mont_m,
  input  logic [N-1:0]   mont_result,
  input  logic           mont_done
);

  state_t       state, state_next;
  logic [N-1:0] x_q, m_q, r2_q, xm_q, acc;
  logic         accept, advance;
  logic         cur_bit, last_bit, exp_zero;

  assign accept  = start && (state == IDLE);
  assign advance = mont_done && !last_bit &&
                   (((state == SQ_WAIT) && !cur_bit) || (state == MUL_WAIT));

  exp_bit_scanner #(.E_W(E_W)) u_scanner (
    .clk      (clk),
    .resetn   (resetn),
    .load     (accept),
    .advance  (advance),
    .e_in     (in_e),
    .cur_bit  (cur_bit),
    .last_bit (last_bit),
    .exp_zero (exp_zero)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= IDLE;
      acc    <= '0;
      result <= '0;
    end else begin
      state <= state_next;
      if (accept)
        acc <= in_r;
      else if (mont_done && ((state == SQ_WAIT) || (state == MUL_WAIT)))
        acc <= mont_result;
      if (mont_done && (state == POST_WAIT))
        result <= mont_result;
    end
  end

  // Operand copies carry no reset: they are always rewritten before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      x_q  <= in_x;
      m_q  <= in_m;
      r2_q <= in_r2;
    end
    if (mont_done && (state == PRE_WAIT))
      xm_q <= mont_result;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (start) state_next = PRE;
      PRE:       state_next = PRE_WAIT;
      PRE_WAIT:  if (mont_done) state_next = exp_zero ? POST : SQ;
      SQ:        state_next = SQ_WAIT;
      SQ_WAIT: begin
        if (mont_done) begin
          if (cur_bit)       state_next = MUL;
          else if (last_bit) state_next = POST;
          else               state_next = SQ;
        end
      end
      MUL:       state_next = MUL_WAIT;
      MUL_WAIT:  if (mont_done) state_next = last_bit ? POST : SQ;
      POST:      state_next = POST_WAIT;
      POST_WAIT: if (mont_done) state_next = FIN;
      FIN:       state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Operands follow the state, so they hold from issue through the done cycle.
  always_comb begin
    mont_a = acc;
    mont_b = acc;
    case (state)
      PRE, PRE_WAIT: begin
        mont_a = x_q;
        mont_b = r2_q;
      end
      MUL, MUL_WAIT:   mont_b = xm_q;
      POST, POST_WAIT: mont_b = N'(1);
      default: ;
    endcase
  end

  assign mont_m     = m_q;
  assign mont_start = (state == PRE) || (state == SQ) || (state == MUL) || (state == POST);
  assign busy       = (state != IDLE);
  assign done       = (state == FIN);

endmodule

// File: tb/tb_modexp_ctrl.sv
// Self-checking bench for modexp_ctrl with a behavioural Montgomery multiplier
// of random 1-20 cycle latency. Honours MODEXP_SKIP_LZ_EN for product counts.
module tb_modexp_ctrl;

  localparam int N   = 1024;
  localparam int E_W = 16;

`ifdef MODEXP_SKIP_LZ_EN
  localparam int ST_3_5  = 7;
  localparam int ST_E0   = 2;
  localparam int ST_5_3  = 6;
  localparam int ST_7_2  = 5;
  localparam int ST_2_10 = 8;
`else
  localparam int ST_3_5  = 20;
  localparam int ST_E0   = 18;
  localparam int ST_5_3  = 20;
  localparam int ST_7_2  = 19;
  localparam int ST_2_10 = 20;
`endif

  logic           clk;
  logic           resetn;
  logic           start;
  logic [N-1:0]   in_x, in_m, in_r, in_r2;
  logic [E_W-1:0] in_e;
  logic [N-1:0]   result;
  logic           done, busy, mont_start;
  logic [N-1:0]   mont_a, mont_b, mont_m;
  logic [N-1:0]   mont_result;
  logic           mont_done;

  int n_checks = 0;
  int n_bad    = 0;

  // Written only by the multiplier model.
  int start_cnt = 0;
  int done_cnt  = 0;
  int ovl_cnt   = 0;
  int stab_cnt  = 0;
  bit pending   = 1'b0;

  // Written only by the main sequence.
  int base_starts, base_dones, base_ovl, base_stab;
  logic [N-1:0] exp_m;

  modexp_ctrl #(.N(N), .E_W(E_W)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .in_x        (in_x),
    .in_m        (in_m),
    .in_r        (in_r),
    .in_r2       (in_r2),
    .in_e        (in_e),
    .result      (result),
    .done        (done),
    .busy        (busy),
    .mont_start  (mont_start),
    .mont_a      (mont_a),
    .mont_b      (mont_b),
    .mont_m      (mont_m),
    .mont_result (mont_result),
    .mont_done   (mont_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [N-1:0] actual, input logic [N-1:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got=%0h want=%0h (low 192 bits)", tag, actual[191:0], expected[191:0]);
    end
  endtask

  // Bit-serial REDC: a*b*2^-N mod m.
  function automatic logic [N-1:0] montRef(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] m);
    logic [N+1:0] t;
    t = '0;
    for (int i = 0; i < N; i++) begin
      if (a[i]) t = t + {2'b00, b};
      if (t[0]) t = t + {2'b00, m};
      t = t >> 1;
    end
    if (t >= {2'b00, m}) t = t - {2'b00, m};
    return t[N-1:0];
  endfunction

  // Plain right-to-left exponentiation with full-width remainders.
  function automatic logic [N-1:0] powRef(input logic [N-1:0] x, input logic [E_W-1:0] e, input logic [N-1:0] m);
    logic [2*N-1:0] mm, acc, base;
    mm   = {{N{1'b0}}, m};
    acc  = {{(2*N-1){1'b0}}, 1'b1} % mm;
    base = {{N{1'b0}}, x} % mm;
    for (int i = 0; i < E_W; i++) begin
      if (e[i]) acc = (acc * base) % mm;
      base = (base * base) % mm;
    end
    return acc[N-1:0];
  endfunction

  function automatic int expStarts(input logic [E_W-1:0] e);
    int pop, msb;
    pop = 0;
    msb = -1;
    for (int i = 0; i < E_W; i++) begin
      if (e[i]) begin
        pop++;
        msb = i;
      end
    end
`ifdef MODEXP_SKIP_LZ_EN
    return (e == '0) ? 2 : 2 + msb + 1 + pop;
`else
    return 2 + E_W + pop;
`endif
  endfunction

  // Montgomery multiplier model; also audits operand stability and overlap.
  initial begin : mont_model
    logic [N-1:0] cap_a, cap_b, prod;
    int lat;
    bit stab_err, aborted;
    mont_done   = 1'b0;
    mont_result = '0;
    lat         = 0;
    stab_err    = 1'b0;
    aborted     = 1'b0;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (mont_done) begin
        mont_done   = 1'b0;
        mont_result = {N{1'b1}};
        pending     = 1'b0;
      end
      if (!resetn && pending) aborted = 1'b1;
      if (mont_start) begin
        start_cnt++;
        if (pending) begin
          ovl_cnt++;
        end else begin
          cap_a    = mont_a;
          cap_b    = mont_b;
          stab_err = (mont_m !== exp_m);
          prod     = montRef(mont_a, mont_b, mont_m);
          lat      = $urandom_range(20, 1);
          pending  = 1'b1;
          aborted  = 1'b0;
        end
      end else if (pending) begin
        if (mont_a !== cap_a || mont_b !== cap_b || mont_m !== exp_m) stab_err = 1'b1;
        lat--;
        if (lat == 0) begin
          if (stab_err && !aborted) stab_cnt++;
          mont_result = prod;
          mont_done   = 1'b1;
        end
      end
    end
  end

  // Called at a negedge: loads operands and pulses start for one cycle.
  task automatic applyStimulus(input logic [N-1:0] x, input logic [E_W-1:0] e, input logic [N-1:0] m);
    logic [2*N-1:0] mm, rr;
    mm    = {{N{1'b0}}, m};
    rr    = ({{(2*N-1){1'b0}}, 1'b1} << N) % mm;
    in_r  = rr[N-1:0];
    rr    = (rr * rr) % mm;
    in_r2 = rr[N-1:0];
    in_x  = x;
    in_e  = e;
    in_m  = m;
    exp_m = m;
    base_starts = start_cnt;
    base_dones  = done_cnt;
    base_ovl    = ovl_cnt;
    base_stab   = stab_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (done) ok = 1'b1;
    end
  endtask

  task automatic finishOp(input string tag, input logic [N-1:0] exp_res, input int exp_starts);
    bit ok;
    waitDone(ok);
    checkOutput({tag, "_done_seen"}, N'(ok), N'(1));
    repeat (3) @(negedge clk);
    checkOutput({tag, "_result"}, result, exp_res);
    checkOutput({tag, "_done_pulses"}, N'(done_cnt - base_dones), N'(1));
    checkOutput({tag, "_mont_starts"}, N'(start_cnt - base_starts), N'(exp_starts));
    checkOutput({tag, "_overlap"}, N'(ovl_cnt - base_ovl), '0);
    checkOutput({tag, "_operands"}, N'(stab_cnt - base_stab), '0);
    checkOutput({tag, "_idle"}, N'(busy), '0);
  endtask

  initial begin : main_seq
    bit ok;
    resetn = 1'b0;
    start  = 1'b0;
    in_x   = '0;
    in_m   = '0;
    in_r   = '0;
    in_r2  = '0;
    in_e   = '0;
    exp_m  = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", N'(busy), '0);
    checkOutput("rst_done", N'(done), '0);
    checkOutput("rst_mont_start", N'(mont_start), '0);
    checkOutput("rst_result", result, '0);

    // Reset outranks a simultaneous start.
    in_x = 3; in_e = 5; in_m = 13; start = 1'b1;
    @(negedge clk);
    checkOutput("rst_over_start", N'(busy), '0);
    start  = 1'b0;
    resetn = 1'b1;
    @(negedge clk);

    applyStimulus(3, 5, 13);
    checkOutput("busy_after_start", N'(busy), N'(1));
    finishOp("pow_3_5_m13", 9, ST_3_5);

    applyStimulus(7, 0, 13);
    finishOp("exp_zero", 1, ST_E0);

    // Second start and operand changes while busy must not disturb the run.
    applyStimulus(5, 3, 13);
    repeat (4) @(negedge clk);
    in_x  = 9;
    in_e  = 16'hFFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_x  = 11;
    in_e  = 16'h00F0;
    finishOp("ignore_start", 8, ST_5_3);

    // Back-to-back: start in the done cycle is dropped, start at done+1 is taken.
    applyStimulus(3, 5, 13);
    waitDone(ok);
    checkOutput("b2b_first_done", N'(ok), N'(1));
    in_x  = 7;
    in_e  = 2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("start_in_done_ignored", N'(busy), '0);
    checkOutput("b2b_first_result", result, 9);
    applyStimulus(7, 2, 13);
    checkOutput("start_done_plus1_taken", N'(busy), N'(1));
    repeat (5) @(negedge clk);
    checkOutput("result_hold", result, 9);
    finishOp("b2b_second", 10, ST_7_2);

    // Abort during a WAIT state, then let the orphaned product arrive late.
    applyStimulus(5, 16'hFFFF, 13);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (pending && !mont_start && !mont_done) ok = 1'b1;
    end
    checkOutput("abort_wait_found", N'(ok), N'(1));
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("abort_busy", N'(busy), '0);
    checkOutput("abort_result", result, '0);
    checkOutput("abort_mont_start", N'(mont_start), '0);
    resetn = 1'b1;
    base_starts = start_cnt;
    base_dones  = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (!pending) ok = 1'b1;
    end
    checkOutput("late_done_drained", N'(ok), N'(1));
    repeat (3) @(negedge clk);
    checkOutput("late_done_busy", N'(busy), '0);
    checkOutput("late_done_starts", N'(start_cnt - base_starts), '0);
    checkOutput("late_done_dones", N'(done_cnt - base_dones), '0);
    applyStimulus(2, 10, 1000003);
    finishOp("after_abort", 1024, ST_2_10);

    // Full-width random operands against the reference exponentiation.
    for (int k = 0; k < 20; k++) begin
      logic [N-1:0]   rm, rx;
      logic [E_W-1:0] re;
      for (int w = 0; w < N / 32; w++) begin
        rm[w*32 +: 32] = $urandom();
        rx[w*32 +: 32] = $urandom();
      end
      rm[0]   = 1'b1;
      rm[N-1] = 1'b1;
      rx      = rx % rm;
      re      = E_W'($urandom());
      applyStimulus(rx, re, rm);
      finishOp($sformatf("rand%0d", k), powRef(rx, re, rm), expStarts(re));
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
